// File: rtl/ex_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_unit_pkg
// Shared definitions for the EX-stage integer divider:
//   - FSM state encoding (EX_DIV_IDLE / EX_DIV_CALC / EX_DIV_DONE, 2 bits)
//   - op codes for DIV.W, MOD.W, DIV.WU, MOD.WU
//   - the div-class op_type value the decoder uses to raise `start`
//   - helpers that split an op code into the op_mod / flag_unsigned fields
// ---------------------------------------------------------------------------
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    EX_DIV_IDLE = 2'd0,
    EX_DIV_CALC = 2'd1,
    EX_DIV_DONE = 2'd2
  } ex_div_state_e;

  typedef enum logic [1:0] {
    OP_DIV_W  = 2'd0,
    OP_MOD_W  = 2'd1,
    OP_DIV_WU = 2'd2,
    OP_MOD_WU = 2'd3
  } ex_div_op_e;

  // ID/EX op_type value identifying the divide class; start = (op_type == OP_TYPE_DIV).
  localparam logic [3:0] OP_TYPE_DIV = 4'd6;

  function automatic logic op_is_mod(input ex_div_op_e op);
    return (op == OP_MOD_W) || (op == OP_MOD_WU);
  endfunction

  function automatic logic op_is_unsigned(input ex_div_op_e op);
    return (op == OP_DIV_WU) || (op == OP_MOD_WU);
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// ---------------------------------------------------------------------------
// ex_div_unit_if
// Bundle between the ID/EX pipeline register / EX stage and the divider.
//   master (EX stage): drives start, op_mod, flag_unsigned, rj_val, rk_val,
//                      reg_d_in, flush; receives stall, done, result, reg_d_out
//   slave  (divider) : the mirror image
// ---------------------------------------------------------------------------
interface ex_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_mod;
  logic             flag_unsigned;
  logic [WIDTH-1:0] rj_val;
  logic [WIDTH-1:0] rk_val;
  logic [4:0]       reg_d_in;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       reg_d_out;

  modport master (
    output start, op_mod, flag_unsigned, rj_val, rk_val, reg_d_in, flush,
    input  stall, done, result, reg_d_out
  );

  modport slave (
    input  start, op_mod, flag_unsigned, rj_val, rk_val, reg_d_in, flush,
    output stall, done, result, reg_d_out
  );
endinterface

// File: rtl/ex_div_unit_div_restoring_step.sv
// ---------------------------------------------------------------------------
// div_restoring_step
// One combinational radix-2 restoring division step on magnitudes.
//   rem_i     : partial remainder (always < divisor_i, or any value if divisor is 0)
//   divisor_i : divisor magnitude
//   bit_i     : next dividend bit, MSB first
//   rem_o     : next partial remainder
//   qbit_o    : quotient bit produced by this step
// Kept as its own module so a radix-4 or unrolled step can replace it.
// ---------------------------------------------------------------------------
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // The shifted remainder needs one extra bit before the compare.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    // When the subtract is taken the difference is < divisor, so the low
    // WIDTH bits of the modular subtraction are exact.
    rem_o   = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div_unit.sv
// ---------------------------------------------------------------------------
// ex_div_unit
// Multi-cycle EX-stage integer divider for DIV.W, MOD.W, DIV.WU, MOD.WU
// (radix-2 restoring, WIDTH steps on magnitudes, signs applied at the end).
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_div_unit_if.slave
//             in : start, op_mod, flag_unsigned, rj_val, rk_val, reg_d_in, flush
//             out: stall, done, result, reg_d_out
//
// Optional feature macro: EX_DIV_EARLY_OUT_EN
//   When defined, an op with |rj| < |rk| or rk == 0 bypasses CALC and
//   completes in cycle 1. When undefined every op takes WIDTH+1 cycles and
//   no magnitude comparator is built.
//
// Timing: accept cycle 0, CALC cycles 1..WIDTH, done in cycle WIDTH+1.
// stall and done are combinational and are forced low by flush.
// ---------------------------------------------------------------------------
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_div_unit_if.slave bus
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  ex_div_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // quot_q starts as the dividend magnitude; each step shifts one dividend
  // bit out of the top and one quotient bit in at the bottom.
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             op_mod_q, op_mod_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dz_q, dz_d;
  logic [4:0]       regd_q, regd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       reg_d_out_q, reg_d_out_d;

  logic             stall;
  logic             done;

  // -------------------------------------------------------------------------
  // Operand conditioning
  // -------------------------------------------------------------------------
  logic             rj_neg;
  logic             rk_neg;
  logic             rk_zero;
  logic [WIDTH-1:0] rj_mag;
  logic [WIDTH-1:0] rk_mag;

  assign rj_neg  = ~bus.flag_unsigned & bus.rj_val[WIDTH-1];
  assign rk_neg  = ~bus.flag_unsigned & bus.rk_val[WIDTH-1];
  assign rj_mag  = rj_neg ? -bus.rj_val : bus.rj_val;
  assign rk_mag  = rk_neg ? -bus.rk_val : bus.rk_val;
  assign rk_zero = (bus.rk_val == '0);

  logic early;
`ifdef EX_DIV_EARLY_OUT_EN
  assign early = rk_zero | (rj_mag < rk_mag);
`else
  assign early = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Restoring step
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (quot_q[WIDTH-1]),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // -------------------------------------------------------------------------
  // Sign fix-up, evaluated while in DONE
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;
  logic [WIDTH-1:0] fin;

  always_comb begin
    // Divide by zero: quotient all ones irrespective of signs. The remainder
    // magnitude equals |rj| on that path, so re-applying the dividend sign
    // reproduces rj_val exactly.
    quot_fin = dz_q ? '1 : (qsign_q ? -quot_q : quot_q);
    rem_fin  = rsign_q ? -rem_q : rem_q;
    fin      = op_mod_q ? rem_fin : quot_fin;
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    op_mod_d    = op_mod_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    dz_d        = dz_q;
    regd_d      = regd_q;
    result_d    = result_q;
    reg_d_out_d = reg_d_out_q;
    stall       = 1'b0;
    done        = 1'b0;

    if (bus.flush) begin
      state_d = EX_DIV_IDLE;
    end else begin
      unique case (state_q)
        EX_DIV_IDLE: begin
          if (bus.start) begin
            stall    = 1'b1;
            op_mod_d = bus.op_mod;
            regd_d   = bus.reg_d_in;
            qsign_d  = rj_neg ^ rk_neg;
            rsign_d  = rj_neg;
            dz_d     = rk_zero;
            dvs_d    = rk_mag;
            cnt_d    = '0;
            quot_d   = rj_mag;
            rem_d    = '0;
            state_d  = EX_DIV_CALC;
            if (early) begin
              quot_d  = rk_zero ? '1 : '0;
              rem_d   = rj_mag;
              state_d = EX_DIV_DONE;
            end
          end
        end

        EX_DIV_CALC: begin
          stall  = 1'b1;
          quot_d = {quot_q[WIDTH-2:0], step_qbit};
          rem_d  = step_rem;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = EX_DIV_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        EX_DIV_DONE: begin
          done        = 1'b1;
          result_d    = fin;
          reg_d_out_d = regd_q;
          state_d     = EX_DIV_IDLE;
        end

        default: state_d = EX_DIV_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EX_DIV_IDLE;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      op_mod_q    <= 1'b0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      dz_q        <= 1'b0;
      regd_q      <= '0;
      result_q    <= '0;
      reg_d_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      op_mod_q    <= op_mod_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      dz_q        <= dz_d;
      regd_q      <= regd_d;
      result_q    <= result_d;
      reg_d_out_q <= reg_d_out_d;
    end
  end

  // result/reg_d_out are registered so they hold between ops, but the value
  // is bypassed straight from the fix-up logic during DONE so it is visible
  // in the same cycle as done.
  assign bus.stall     = stall;
  assign bus.done      = done;
  assign bus.result    = done ? fin : result_q;
  assign bus.reg_d_out = done ? regd_q : reg_d_out_q;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle integer divider in the EX stage; reads the operands and decode fields held in the ID/EX pipeline register.
- Implements DIV.W, MOD.W, DIV.WU and MOD.WU with a radix-2 restoring algorithm.
- Back-pressures the ID/EX register through `stall` while an operation is in flight; that signal feeds the register's write-enable logic.
- Aborts cleanly on pipeline flush.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid divide/mod instruction (ID/EX op decoded as div class).
- op_mod  in  1  0 = quotient, 1 = remainder.
- flag_unsigned  in  1  1 = unsigned operation (xx.WU).
- rj_val  in  WIDTH  dividend (forwarded rj).
- rk_val  in  WIDTH  divisor (forwarded rk).
- reg_d_in  in  5  destination register index.
- flush  in  1  pipeline flush; aborts any operation.
- stall  out  1  hold ID/EX and earlier stages.
- done  out  1  result valid this cycle.
- result  out  WIDTH  quotient or remainder.
- reg_d_out  out  5  destination index of the result.

Behaviour:
- States are IDLE, CALC and DONE. On reset: state = IDLE; iteration counter, quotient, remainder, result and reg_d_out all zero; stall = 0; done = 0.
- IDLE with start=1 and flush=0:
  - latch op_mod, flag_unsigned and reg_d_in;
  - latch |rj_val| and |rk_val| (two's-complement magnitudes when signed);
  - latch quotient sign (sign(rj) XOR sign(rk)) and remainder sign (sign(rj));
  - counter = 0; go to CALC.
- CALC: one restoring step per cycle, MSB-first.
  - Shift the remainder left by 1 and bring in the next dividend bit.
  - If the shifted remainder is greater than or equal to the divisor, subtract the divisor and set the quotient bit to 1.
  - After WIDTH steps (counter == WIDTH-1) go to DONE.
- DONE:
  - apply signs (negate the quotient if its sign is set, negate the remainder if the dividend was negative);
  - drive result, with done = 1 for exactly one cycle;
  - return to IDLE.
- Latency: the start-accept cycle is cycle 0; CALC covers cycles 1..WIDTH; done is asserted in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- stall = (state==IDLE & start & ~flush) | (state==CALC). stall is 0 in DONE, so ID/EX advances in the same cycle the result is consumed.
- A back-to-back start is sampled only in IDLE. The DONE cycle never accepts a new op.
- Divide by zero (rk = 0):
  - quotient = all ones;
  - remainder = rj_val unchanged, sign rules not applied;
  - takes the full-length path.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
- Flush in any state: next state IDLE, done = 0, stall = 0 in that same cycle (combinational), and no result is produced. Flush has priority over start.
- Reset asserted mid-operation: immediate return to the reset values listed above.
- result and reg_d_out hold their last value outside DONE; the consumer qualifies them with done.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN.
- Defined: in IDLE on start, if |rj| < |rk| or rk == 0, skip CALC and go directly to DONE in cycle 1.
  - |rj| < |rk|: quotient = 0, remainder = rj_val.
  - rk == 0: the divide-by-zero values above.
- Undefined: every operation takes the full WIDTH+1 latency; no comparator is instantiated.

Decomposition:
- Shared defs header holds:
  - state encodings EX_DIV_IDLE/CALC/DONE (2 bits);
  - the op codes for DIV.W, MOD.W, DIV.WU and MOD.WU;
  - the div-class op_type value used to generate start.
- One sub-module, div_restoring_step: combinational single step.
  - In: remainder, divisor, next dividend bit.
  - Out: next remainder, quotient bit.
  - Kept separate so a radix-4 or unrolled variant can replace it.

Test Plan:
- Unsigned 7 / 2, op_mod=0, then a repeat with op_mod=1 → result 3, then result 1; done exactly in cycle 33 after accept; stall high in cycles 0–32.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → DIV.W 0xFFFFFFFD; MOD.W 0xFFFFFFFF.
- 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0; the unsigned variant gives quotient 0, remainder 0x80000000.
- Divide by zero, rj = 0x1234 → quotient 0xFFFFFFFF, remainder 0x1234; with EX_DIV_EARLY_OUT_EN, done in cycle 1.
- Flush in cycle 10 of CALC with start held → stall drops in cycle 10, no done; a new start in cycle 11 produces its correct result in cycle 44.
- rst_n pulled low in cycle 5 of CALC → outputs zero immediately (asynchronously); after release, idle with stall = 0 until the next start.
